branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Two-stage pipelined branch resolution unit for the RV32/RV64 core, taking over from the single-cycle combinational branch comparator. It accepts one conditional branch per cycle over a valid/ready handshake. It decodes all six RISC-V branch conditions from funct3 and computes the target and redirect PC. It flags misprediction against the front-end's predicted direction and sits between the execute-stage operand bypass and the fetch redirect logic.

## Interface
Parameters:
- XLEN, 32: operand and PC width (32 or 64).
- CNT_W, 32: performance counter width (used only with BRU_PERF_CNT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  branch presented.
- in_ready  out  1  unit can accept the presented branch this cycle.
- in_funct3  in  3  branch condition (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111).
- in_rs1, in_rs2  in  XLEN  operands.
- in_pc  in  XLEN  branch instruction PC.
- in_imm  in  XLEN  sign-extended B-immediate.
- in_pred_taken  in  1  front-end predicted direction.
- flush  in  1  kill all in-flight entries.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  branch resolved taken.
- out_redirect_pc  out  XLEN  target if taken, else pc+4.
- out_mispredict  out  1  out_taken != pred_taken.
- out_illegal  out  1  funct3 is 010 or 011.
- perf_clr  in  1  clear counters (only with BRU_PERF_CNT_EN).
- perf_br_cnt, perf_mis_cnt  out  CNT_W  counters (only with BRU_PERF_CNT_EN).

## Operation
- Stage 1 (S1) registers:
  - eq = (rs1 == rs2);
  - lts = signed rs1 < rs2;
  - ltu = unsigned rs1 < rs2;
  - target = pc + imm, modulo 2^XLEN;
  - fall = pc + 4, modulo 2^XLEN;
  - funct3 and pred_taken.
- Stage 2 (S2) registers the resolved taken, redirect_pc, mispredict and illegal values.
- Taken per funct3:
  - BEQ = eq; BNE = !eq;
  - BLT = lts; BGE = !lts;
  - BLTU = ltu; BGEU = !ltu.
- Illegal funct3 (010/011): taken=0, redirect_pc=fall, illegal=1, mispredict = pred_taken.
- Signed compare must be correct at every sign combination and at the extremes (most-negative vs most-positive).
- Flow control:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || s2_load.
  - out_valid = s2_valid.
  - S2 outputs stay stable while out_valid && !out_ready.
- Flush:
  - s1_valid and s2_valid are cleared at the next edge.
  - An input accepted in the same cycle is discarded.
  - Flush has priority over any load.
  - in_ready is not gated by flush.
- Reset values:
  - s1_valid = 0, s2_valid = 0, so out_valid = 0;
  - out_taken, out_mispredict and out_illegal = 0;
  - out_redirect_pc = 0;
  - counters = 0.
- A reset asserted mid-operation drops all in-flight entries asynchronously.

## Timing
- Latency: a branch accepted at edge N has out_valid high after edge N+1 (2-cycle latency).
- Throughput: 1 branch per cycle while out_ready = 1.
- Back-pressure with out_ready = 0:
  - S2 holds its result.
  - S1 fills and in_ready drops the cycle after S1 becomes valid.
  - Nothing is lost or duplicated.
- When out_ready returns high, S1 advances into S2 in the same edge the S2 result is consumed, and in_ready is high combinationally in that cycle.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready only.

## Configuration
- BRU_PERF_CNT_EN defined:
  - perf_br_cnt increments on each out_valid && out_ready.
  - perf_mis_cnt increments on each out_valid && out_ready && out_mispredict.
  - Both counters saturate at 2^CNT_W−1.
  - perf_clr zeroes both synchronously and wins over a same-cycle increment.
  - A flushed entry is never counted.
- BRU_PERF_CNT_EN undefined:
  - perf_clr, perf_br_cnt and perf_mis_cnt ports and all counter logic are absent.
  - Datapath behaviour is identical.

## Test plan
- BEQ, rs1 = rs2 = 0x1234, pc = 0x100, imm = 0x20, pred_taken = 0, out_ready = 1 -> two edges later:
  - out_taken = 1, out_redirect_pc = 0x120, out_mispredict = 1.
- BLT vs BLTU, rs1 = 0xFFFFFFFF, rs2 = 1:
  - BLT -> taken = 1.
  - BLTU -> taken = 0, redirect = pc+4.
  - BGE and BGEU give the opposite results.
- Back-to-back stream of 4 branches with out_ready low for 3 cycles mid-stream -> all 4 results emerge in order and none is duplicated; in_ready falls exactly when S1 and S2 are both full.
- flush asserted while S1 and S2 are valid and in_valid = 1 -> next cycle out_valid = 0 and no result from any of the three branches appears.
- funct3 = 010, pred_taken = 1 -> out_illegal = 1, taken = 0, mispredict = 1; pc = 0xFFFFFFFC with imm = 8 wraps to target 0x4.
- With BRU_PERF_CNT_EN and CNT_W = 2:
  - 5 accepted mispredicted branches -> both counters saturate at 3.
  - perf_clr asserted together with an output handshake -> both counters read 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Two-stage pipelined conditional branch resolver with valid/ready flow control.
// Optional perf counters are enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int XLEN = 32
`ifdef BRU_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            out_mispredict,
  output logic            out_illegal
`ifdef BRU_PERF_CNT_EN
  ,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_br_cnt,
  output logic [CNT_W-1:0] perf_mis_cnt
`endif
);

  logic            r_s1_valid;
  logic            r_s1_eq;
  logic            r_s1_lts;
  logic            r_s1_ltu;
  logic [XLEN-1:0] r_s1_target;
  logic [XLEN-1:0] r_s1_fall;
  logic [2:0]      r_s1_funct3;
  logic            r_s1_pred;

  logic            r_s2_valid;
  logic            r_s2_taken;
  logic [XLEN-1:0] r_s2_redirect;
  logic            r_s2_mis;
  logic            r_s2_ill;

  logic w_s1_load;
  logic w_s2_load;
  logic w_taken;
  logic w_ill;

  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_s1_load = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_eq     <= 1'b0;
      r_s1_lts    <= 1'b0;
      r_s1_ltu    <= 1'b0;
      r_s1_target <= '0;
      r_s1_fall   <= '0;
      r_s1_funct3 <= 3'b000;
      r_s1_pred   <= 1'b0;
    end else begin
      if (flush)
        r_s1_valid <= 1'b0;
      else if (w_s1_load)
        r_s1_valid <= 1'b1;
      else if (w_s2_load)
        r_s1_valid <= 1'b0;
      if (w_s1_load && !flush) begin
        r_s1_eq     <= (in_rs1 == in_rs2);
        r_s1_lts    <= ($signed(in_rs1) < $signed(in_rs2));
        r_s1_ltu    <= (in_rs1 < in_rs2);
        r_s1_target <= in_pc + in_imm;
        r_s1_fall   <= in_pc + XLEN'(4);
        r_s1_funct3 <= in_funct3;
        r_s1_pred   <= in_pred_taken;
      end
    end
  end

  always_comb begin
    w_taken = 1'b0;
    w_ill   = 1'b0;
    unique case (r_s1_funct3)
      3'b000: w_taken = r_s1_eq;
      3'b001: w_taken = !r_s1_eq;
      3'b100: w_taken = r_s1_lts;
      3'b101: w_taken = !r_s1_lts;
      3'b110: w_taken = r_s1_ltu;
      3'b111: w_taken = !r_s1_ltu;
      3'b010: w_ill   = 1'b1;
      3'b011: w_ill   = 1'b1;
    endcase
  end

  // S2 data only moves on a load, so it holds under back-pressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid    <= 1'b0;
      r_s2_taken    <= 1'b0;
      r_s2_redirect <= '0;
      r_s2_mis      <= 1'b0;
      r_s2_ill      <= 1'b0;
    end else begin
      if (flush)
        r_s2_valid <= 1'b0;
      else if (w_s2_load)
        r_s2_valid <= 1'b1;
      else if (out_ready)
        r_s2_valid <= 1'b0;
      if (w_s2_load && !flush) begin
        r_s2_taken    <= w_taken;
        r_s2_redirect <= w_taken ? r_s1_target : r_s1_fall;
        r_s2_mis      <= w_taken ^ r_s1_pred;
        r_s2_ill      <= w_ill;
      end
    end
  end

  assign out_valid       = r_s2_valid;
  assign out_taken       = r_s2_taken;
  assign out_redirect_pc = r_s2_redirect;
  assign out_mispredict  = r_s2_mis;
  assign out_illegal     = r_s2_ill;

`ifdef BRU_PERF_CNT_EN
  logic             w_fire;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  // the S2 entry being flushed is not counted
  assign w_fire = r_s2_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (perf_clr) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (w_fire) begin
      if (r_br_cnt != {CNT_W{1'b1}})
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (r_s2_mis && (r_mis_cnt != {CNT_W{1'b1}}))
        r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end
  end

  assign perf_br_cnt  = r_br_cnt;
  assign perf_mis_cnt = r_mis_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: conditions, wrap, back-pressure,
// flush, async reset and (with BRU_PERF_CNT_EN) saturating counters.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
`ifdef BRU_PERF_CNT_EN
  localparam int CNT_W = 2;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_mispredict;
  logic            out_illegal;
`ifdef BRU_PERF_CNT_EN
  logic             perf_clr;
  logic [CNT_W-1:0] perf_br_cnt;
  logic [CNT_W-1:0] perf_mis_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN(XLEN)
`ifdef BRU_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_funct3       (in_funct3),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_pc           (in_pc),
    .in_imm          (in_imm),
    .in_pred_taken   (in_pred_taken),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_taken       (out_taken),
    .out_redirect_pc (out_redirect_pc),
    .out_mispredict  (out_mispredict),
    .out_illegal     (out_illegal)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_clr        (perf_clr),
    .perf_br_cnt     (perf_br_cnt),
    .perf_mis_cnt    (perf_mis_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    in_valid      = 1'b1;
    in_funct3     = f3;
    in_rs1        = a;
    in_rs2        = b;
    in_pc         = pc;
    in_imm        = imm;
    in_pred_taken = pred;
  endtask

  task automatic run_one(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred, input logic e_tk,
                         input logic [31:0] e_pc, input logic e_mis,
                         input logic e_ill);
    drive(f3, a, b, pc, imm, pred);
    step();
    in_valid = 1'b0;
    chk({tag, "_lat"}, out_valid, 0);
    step();
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_tk"}, out_taken, e_tk);
    chk({tag, "_pc"}, out_redirect_pc, e_pc);
    chk({tag, "_mis"}, out_mispredict, e_mis);
    chk({tag, "_ill"}, out_illegal, e_ill);
    step();
    chk({tag, "_done"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_funct3 = 3'b000;
    in_rs1 = '0;
    in_rs2 = '0;
    in_pc = '0;
    in_imm = '0;
    in_pred_taken = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
`ifdef BRU_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    #2;
    chk("rst_vld", out_valid, 0);
    chk("rst_tk", out_taken, 0);
    chk("rst_pc", out_redirect_pc, 0);
    chk("rst_mis", out_mispredict, 0);
    chk("rst_ill", out_illegal, 0);
    chk("rst_rdy", in_ready, 1);
`ifdef BRU_PERF_CNT_EN
    chk("rst_brc", perf_br_cnt, 0);
    chk("rst_misc", perf_mis_cnt, 0);
`endif
    step();
    step();
    rst = 1'b0;
    step();

    run_one("beq", 3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20, 1'b0,
            1'b1, 32'h120, 1'b1, 1'b0);
    run_one("blt", 3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b1,
            1'b1, 32'h240, 1'b0, 1'b0);
    run_one("bltu", 3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b1,
            1'b0, 32'h204, 1'b1, 1'b0);
    run_one("bge", 3'b101, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b0,
            1'b0, 32'h204, 1'b0, 1'b0);
    run_one("bgeu", 3'b111, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b0,
            1'b1, 32'h240, 1'b1, 1'b0);
    run_one("blt_ext", 3'b100, 32'h80000000, 32'h7FFFFFFF, 32'h300,
            32'hFFFFFFF0, 1'b1, 1'b1, 32'h2F0, 1'b0, 1'b0);
    run_one("bge_ext", 3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h300,
            32'h8, 1'b0, 1'b1, 32'h308, 1'b1, 1'b0);
    run_one("bne_eq", 3'b001, 32'h55, 32'h55, 32'h400, 32'h8, 1'b0,
            1'b0, 32'h404, 1'b0, 1'b0);
    run_one("illegal", 3'b010, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h8, 1'b1,
            1'b0, 32'h0, 1'b1, 1'b1);
    run_one("wrap", 3'b000, 32'h7, 32'h7, 32'hFFFFFFFC, 32'h8, 1'b1,
            1'b1, 32'h4, 1'b0, 1'b0);

    // four-branch stream with a three-cycle stall
    drive(3'b000, 0, 0, 32'h1000, 32'h10, 1'b1);
    #1;
    chk("st_rdyA", in_ready, 1);
    step();
    drive(3'b000, 0, 0, 32'h2000, 32'h10, 1'b1);
    #1;
    chk("st_rdyB", in_ready, 1);
    step();
    drive(3'b000, 0, 0, 32'h3000, 32'h10, 1'b1);
    out_ready = 1'b0;
    #1;
    chk("st_outA", out_redirect_pc, 32'h1010);
    chk("st_full", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("st_holdv", out_valid, 1);
      chk("st_hold", out_redirect_pc, 32'h1010);
      chk("st_stall", in_ready, 0);
    end
    step();
    out_ready = 1'b1;
    #1;
    chk("st_rel", in_ready, 1);
    chk("st_outA2", out_redirect_pc, 32'h1010);
    step();
    drive(3'b000, 0, 0, 32'h4000, 32'h10, 1'b1);
    #1;
    chk("st_vB", out_valid, 1);
    chk("st_outB", out_redirect_pc, 32'h2010);
    step();
    in_valid = 1'b0;
    #1;
    chk("st_outC", out_redirect_pc, 32'h3010);
    step();
    chk("st_vD", out_valid, 1);
    chk("st_outD", out_redirect_pc, 32'h4010);
    step();
    chk("st_empty", out_valid, 0);

    // flush with both stages full and a branch presented
    out_ready = 1'b0;
    drive(3'b000, 0, 0, 32'h5000, 32'h10, 1'b0);
    step();
    drive(3'b000, 0, 0, 32'h6000, 32'h10, 1'b0);
    step();
    drive(3'b000, 0, 0, 32'h7000, 32'h10, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_pre", out_valid, 1);
    chk("fl_rdy", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl_kill", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_gone", out_valid, 0);
    end

    // flush on an idle pipe drops the branch accepted that cycle
    drive(3'b000, 0, 0, 32'h8000, 32'h10, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_rdy_ungated", in_ready, 1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("fl_drop", out_valid, 0);
    end

    // asynchronous reset with entries in flight
    drive(3'b000, 0, 0, 32'h9000, 32'h10, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk("ar_pre", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_vld", out_valid, 0);
    chk("ar_pc", out_redirect_pc, 0);
    step();
    rst = 1'b0;
    step();
    chk("ar_after", out_valid, 0);

`ifdef BRU_PERF_CNT_EN
    for (int i = 0; i < 5; i++) begin
      drive(3'b000, 0, 0, 32'hA000, 32'h10, 1'b0);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("pc_brsat", perf_br_cnt, 3);
    chk("pc_missat", perf_mis_cnt, 3);
    drive(3'b000, 0, 0, 32'hB000, 32'h10, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk("pc_clrv", out_valid, 1);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("pc_brclr", perf_br_cnt, 0);
    chk("pc_misclr", perf_mis_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
